mem_ctrl: RTL and testbench

Memory controller that serves the IF stage (instruction fetch) and the MEM stage (load/store) over the single byte-wide RAM port. It is the responder end of the request/done handshake that the pipeline stages initiate. It serialises 1/2/4-byte accesses into byte beats, reassembles read data little-endian, and arbitrates between the two requesters.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_arb.sv | 24 ++
 rtl/mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller.
// - Default address and data widths.
// - Enable/disable and zero-word constants.
// - FSM state encoding: IDLE, RD, WR.
// - Access length codes, stored as bytes minus 1.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd3
  } len_e;

  // Number of byte beats for a length code.
  function automatic logic [2:0] len_beats(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Arbitration between the fetch and load/store requesters. It is only
// meaningful while the controller is idle.
//   idle      : controller is in IDLE and may accept a request
//   if_req    : fetch request
//   if_flush  : fetch redirect; blocks fetch acceptance this cycle
//   mem_req   : load/store request; wins over fetch
//   grant_if  : accept the fetch at this edge
//   grant_mem : accept the load/store at this edge
module mem_ctrl_arb (
  input  logic idle,
  input  logic if_req,
  input  logic if_flush,
  input  logic mem_req,
  output logic grant_if,
  output logic grant_mem
);

  always_comb begin
    grant_mem = idle & mem_req;
    // A flush in IDLE means the presented fetch address is stale.
    grant_if  = idle & if_req & ~if_flush & ~mem_req;
  end

endmodule

// File: rtl/mem_ctrl.sv
// The controller connects two requesters to one byte-wide RAM port:
// instruction fetch (IF) and load/store (MEM). Each accepted access is
// broken into byte beats. Read bytes are reassembled little-endian.
// Every output is registered. The only exception is if_done, which is
// gated by if_flush so that a flush in the done cycle hides the pulse.
//   clk, rst            : clock, synchronous active-low reset
//   rdy                 : low freezes every register
//   if_req/if_addr      : 4-byte fetch request, held until if_done
//   if_flush            : abandon an in-flight fetch
//   if_done/if_inst     : fetch completion pulse and word
//   mem_req/we/addr/len/wdata : load/store request, held until mem_done
//   mem_done/mem_rdata  : access completion pulse and zero-extended data
//   ram_a/ram_dout/ram_wr : RAM address, write byte, write strobe
//   ram_din             : RAM read byte, one cycle after ram_a
// DATA_W is assumed >= 32 (a word access fills bytes 0..3).
import mem_ctrl_pkg::*;

module mem_ctrl #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;      // edges taken since acceptance
  logic [2:0]        n_q, n_d;          // beats in this access
  logic              is_if_q, is_if_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              grant_if, grant_mem;
  logic [2:0]        nxt, idx;

  mem_ctrl_arb u_arb (
    .idle      (state_q == ST_IDLE),
    .if_req    (if_req),
    .if_flush  (if_flush),
    .mem_req   (mem_req),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  // Timeline after acceptance at edge 0:
  // - Beat k drives ram_a from edge k, for k = 0..n-1.
  // - The byte for beat k is on ram_din after edge k+1 and is captured at edge k+2.
  // - At edge n+1 the last byte is captured and the done pulse is raised.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    is_if_d     = is_if_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = DISABLE;
    if_done_d   = DISABLE;
    mem_done_d  = DISABLE;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    nxt         = cnt_q + 3'd1;
    idx         = cnt_q - 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (grant_mem) begin
          state_d    = mem_we ? ST_WR : ST_RD;
          is_if_d    = DISABLE;
          n_d        = len_beats(mem_len);
          base_d     = mem_addr;
          wdata_d    = mem_wdata;
          cnt_d      = '0;
          buf_d      = '0;
          ram_a_d    = mem_addr;
          ram_wr_d   = mem_we;
          ram_dout_d = mem_wdata[7:0];
        end else if (grant_if) begin
          state_d = ST_RD;
          is_if_d = ENABLE;
          n_d     = len_beats(LEN_WORD);
          base_d  = if_addr;
          wdata_d = DATA_W'(ZERO_WORD);
          cnt_d   = '0;
          buf_d   = '0;
          ram_a_d = if_addr;
        end
      end

      ST_RD, ST_WR: begin
        if (is_if_q && if_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = nxt;
          if (state_q == ST_RD && cnt_q != 3'd0)
            buf_d[{idx[1:0], 3'b000} +: 8] = ram_din;
          if (nxt < n_q) begin
            ram_a_d    = base_q + ADDR_W'(nxt);
            ram_wr_d   = (state_q == ST_WR);
            ram_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          end
          if (cnt_q == n_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (is_if_q) begin
              if_done_d = ENABLE;
              if_inst_d = buf_d;
            end else begin
              mem_done_d = ENABLE;
              if (state_q == ST_RD) mem_rdata_d = buf_d;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      is_if_q     <= DISABLE;
      base_q      <= '0;
      wdata_q     <= DATA_W'(ZERO_WORD);
      buf_q       <= DATA_W'(ZERO_WORD);
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= DISABLE;
      if_done_q   <= DISABLE;
      mem_done_q  <= DISABLE;
      if_inst_q   <= DATA_W'(ZERO_WORD);
      mem_rdata_q <= DATA_W'(ZERO_WORD);
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      is_if_q     <= is_if_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // A flush that lands in the done cycle still cancels the fetch.
  assign if_done   = if_done_q & ~if_flush;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl. It contains a byte RAM model and a shadow memory
// that holds the expected contents. Expected load and fetch words are
// assembled from the shadow in little-endian order.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, ram_wr;
  logic [31:0] if_inst, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  // RAM model, indexed by the low 12 address bits. It ignores cycles where rdy is low.
  logic [7:0]  ram_m [0:4095];
  logic        clr, pl_en;
  logic [11:0] pl_a;
  logic [7:0]  pl_d;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram_m[i] <= 8'h00;
    end else if (pl_en) begin
      ram_m[pl_a] <= pl_d;
    end else if (rdy && ram_wr) begin
      ram_m[ram_a[11:0]] <= ram_dout;
    end
    if (rdy) ram_din <= ram_m[ram_a[11:0]];
  end

  logic [7:0] sh [0:4095];

  function automatic logic [31:0] sh_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] t;
    w = '0;
    for (int k = 0; k < n; k++) begin
      t = a + 32'(k);
      w[8*k +: 8] = sh[t[11:0]];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ram_a"}, ram_a, 0);
    chk({tag, "_ram_wr"}, ram_wr, 0);
    chk({tag, "_ram_dout"}, ram_dout, 0);
    chk({tag, "_if_done"}, if_done, 0);
    chk({tag, "_mem_done"}, mem_done, 0);
    chk({tag, "_if_inst"}, if_inst, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a[11:0]; pl_d = d;
    sh[a[11:0]] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Performs one access that is accepted at the first edge.
  // - stall_at >= 1 drops rdy after that edge for three edges.
  // - It checks beat addresses, write strobes, frozen outputs, latency and read data.
  task automatic op(input bit is_if, input bit we, input logic [31:0] addr,
                    input logic [1:0] len, input logic [31:0] wd,
                    input int stall_at, output logic [31:0] rd);
    int n, e, act;
    bit got, was, wr_op;
    logic [31:0] seen[$];
    logic [31:0] pa, t;
    logic pw;
    n = is_if ? 4 : int'(len) + 1;
    wr_op = we && !is_if;
    if (is_if) begin if_addr = addr; if_req = 1'b1; end
    else begin
      mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wd; mem_req = 1'b1;
    end
    e = 0; act = 0; got = 1'b0;
    while (!got && e < 60) begin
      pa = ram_a; pw = ram_wr;
      @(posedge clk); #1;
      e++;
      was = rdy;
      if (was) act++;
      if (!was) begin
        chk("frozen_ram_a", ram_a, pa);
        chk("frozen_ram_wr", ram_wr, pw);
      end else if (act <= n) begin
        seen.push_back(ram_a);
        chk("beat_wr", ram_wr, wr_op);
        if (wr_op) chk("beat_dout", ram_dout, wd[8*(act-1) +: 8]);
      end else begin
        chk("post_beat_wr", ram_wr, 0);
      end
      if (stall_at >= 1 && e == stall_at) rdy = 1'b0;
      if (stall_at >= 1 && e == stall_at + 3) rdy = 1'b1;
      got = is_if ? if_done : mem_done;
    end
    chk("done_seen", got, 1);
    chk("latency", e, n + 2 + (stall_at >= 1 ? 3 : 0));
    chk("beat_count", seen.size(), n);
    for (int k = 0; k < n && k < seen.size(); k++) chk("beat_addr", seen[k], addr + 32'(k));
    rd = is_if ? if_inst : mem_rdata;
    if (wr_op) begin
      for (int k = 0; k < n; k++) begin
        t = addr + 32'(k);
        sh[t[11:0]] = wd[8*k +: 8];
      end
    end else begin
      chk(is_if ? "fetch_data" : "load_data", rd, sh_word(addr, n));
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mr, ir, wd, a;
    logic [1:0]  len;
    int md, id, sa;
    bit dseen;

    rst = 1'b0; rdy = 1'b1; clr = 1'b1; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    if_req = 0; if_flush = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    for (int i = 0; i < 4096; i++) sh[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    clr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Fetch a known instruction word.
    preload(32'h100, 8'h13); preload(32'h101, 8'h00);
    preload(32'h102, 8'h50); preload(32'h103, 8'h00);
    op(1, 0, 32'h100, 2'd3, 32'h0, -1, rd);
    chk("fetch_const", rd, 32'h00500013);

    // Store a byte, then load a halfword that covers it.
    preload(32'h21, 8'hCD);
    op(0, 1, 32'h20, 2'd0, 32'h000000AB, -1, rd);
    op(0, 0, 32'h20, 2'd1, 32'h0, -1, rd);
    chk("load_half_const", rd, 32'h0000CDAB);

    // Contention: MEM must win, and IF is accepted at the edge that ends the mem_done cycle.
    for (int k = 0; k < 4; k++) begin
      preload(32'h40 + 32'(k), 8'($urandom));
      preload(32'h300 + 32'(k), 8'($urandom));
    end
    mem_we = 0; mem_addr = 32'h40; mem_len = 2'd3; mem_req = 1;
    if_addr = 32'h300; if_req = 1;
    md = 0; id = 0; mr = '0; ir = '0;
    for (int e = 1; e <= 40 && id == 0; e++) begin
      @(posedge clk); #1;
      if (mem_done) begin md = e; mr = mem_rdata; mem_req = 0; end
      if (if_done) begin id = e; ir = if_inst; if_req = 0; end
    end
    mem_req = 0; if_req = 0;
    chk("cont_mem_done_edge", md, 6);
    chk("cont_if_done_edge", id, 12);
    chk("cont_mem_data", mr, sh_word(32'h40, 4));
    chk("cont_if_data", ir, sh_word(32'h300, 4));

    // Flush during beat 2: the fetch is dropped, and a new fetch then completes.
    if_addr = 32'h100; if_req = 1;
    dseen = 0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      if (if_done) dseen = 1;
    end
    if_flush = 1;
    @(posedge clk); #1;
    if (if_done) dseen = 1;
    if_flush = 0; if_req = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (if_done) dseen = 1;
    end
    chk("flush_no_done", dseen, 0);
    for (int k = 0; k < 4; k++) preload(32'h200 + 32'(k), 8'($urandom));
    op(1, 0, 32'h200, 2'd3, 32'h0, -1, rd);

    // Store a word across the top of the address space with three rdy-low cycles, then read it back.
    wd = $urandom;
    op(0, 1, 32'hFFFF_FFFE, 2'd3, wd, 2, rd);
    op(0, 0, 32'hFFFF_FFFE, 2'd3, 32'h0, -1, rd);
    chk("wrap_readback", rd, wd);

    // Reset during beat 1 of a read: outputs clear and no done pulse follows.
    mem_we = 0; mem_addr = 32'h900; mem_len = 2'd3; mem_req = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0; mem_req = 0;
    @(posedge clk); #1;
    chk_zero("midreset");
    rst = 1;
    dseen = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (mem_done || if_done) dseen = 1;
    end
    chk("midreset_no_done", dseen, 0);
    op(0, 0, 32'h100, 2'd3, 32'h0, -1, rd);

    // Random mix of stores, loads and fetches, with occasional rdy stalls.
    for (int i = 0; i < 40; i++) begin
      a  = 32'h800 + 32'($urandom_range(0, 60));
      wd = $urandom;
      case ($urandom_range(0, 2))
        0: len = 2'd0;
        1: len = 2'd1;
        default: len = 2'd3;
      endcase
      sa = ($urandom_range(0, 3) == 0) ? 2 : -1;
      case ($urandom_range(0, 2))
        0: op(0, 1, a, len, wd, sa, rd);
        1: op(0, 0, a, len, 32'h0, sa, rd);
        default: op(1, 0, a, 2'd3, 32'h0, sa, rd);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
